cla_sub_46bit_seq: RTL and testbench
====================================

# cla_sub_46bit_seq

Multi-cycle 46-bit subtractor: the inverse operation of the team's single-cycle carry-lookahead adder, sharing its operand and result format. It accepts two operands through a valid/ready handshake and computes `i_op1 - i_op2` one CHUNK-bit carry-lookahead slice per cycle, with a registered borrow between slices. It returns `{borrow, difference}` through a second valid/ready handshake. It sits downstream of operand registers in the adder test datapath, where a narrow per-cycle carry chain is preferred over a full-width one.

## Interface
- `WIDTH`, 46, operand width in bits.
- `CHUNK`, 12, bits processed per cycle; NCHUNK = ceil(WIDTH/CHUNK) = 4 at defaults.
- `i_clk`  input  1  rising-edge clock; only clock.
- `i_rst_n`  input  1  synchronous, active-low reset.
- `i_valid`  input  1  operands valid.
- `o_ready`  output  1  block can accept operands.
- `i_op1`  input  WIDTH  minuend (unsigned).
- `i_op2`  input  WIDTH  subtrahend (unsigned).
- `o_valid`  output  1  result valid.
- `i_ready`  input  1  consumer accepts result.
- `o_result`  output  WIDTH+1  {borrow, difference}; bit WIDTH = borrow.
- `o_ovf`  output  1  signed overflow; present only with SUB_SIGNED_OVF_EN.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On an edge with i_valid=1, latch i_op1 and ~i_op2, set carry register c=1, chunk count cnt=0, go to BUSY.
- BUSY:
  - o_ready=0.
  - Each edge computes slice cnt: {c', s} = op1[slice] + ~op2[slice] + c, using per-bit G=a&b and P=a|b lookahead inside the slice.
  - Stores s into the difference bits of that slice and sets c=c', cnt=cnt+1.
  - The last slice covers only bits CHUNK*(NCHUNK-1) .. WIDTH-1. Its carry-out is taken from bit WIDTH-1, not from the padded chunk top.
  - After slice NCHUNK-1, go to DONE.
- DONE:
  - o_valid=1, o_ready=0.
  - o_result = {~c, difference}, so borrow=1 exactly when i_op1 < i_op2 (unsigned).
  - Difference = (i_op1 - i_op2) mod 2^WIDTH.
  - On an edge with i_ready=1, go to IDLE.
- i_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- o_result and o_ovf are held stable throughout DONE, regardless of how long i_ready stays low.
- o_result keeps its last value in IDLE; only o_valid qualifies it.

## Timing
- Acceptance edge E (IDLE, i_valid=1). BUSY occupies edges E+1 .. E+NCHUNK. o_valid rises in the cycle after edge E+NCHUNK. Latency from acceptance to o_valid is NCHUNK cycles (4 at defaults).
- Result handshake completes on an edge with o_valid&i_ready. o_ready is 1 in the following cycle. Minimum initiation interval is NCHUNK+2 cycles.
- Synchronous reset (i_rst_n=0 at an edge):
  - State goes to IDLE; o_valid=0, o_result=0, o_ovf=0, c=0, cnt=0.
  - o_ready=0 while i_rst_n=0, then 1 in the first cycle after release.
- Reset during BUSY or DONE abandons the operation. No result is ever presented for it.

## Configuration
- `SUB_SIGNED_OVF_EN` defined:
  - Adds output o_ovf, valid with o_valid and registered with o_result.
  - o_ovf=1 when two's-complement i_op1 - i_op2 overflows: operand sign bits differ and the difference sign bit differs from i_op1's sign bit.
  - Requires latching i_op1[WIDTH-1] and i_op2[WIDTH-1] at acceptance.
- Undefined: o_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic: i_op1=5, i_op2=3, i_ready=1 -> o_valid exactly 4 cycles after acceptance, o_result=47'h0_0000_0000_0002.
- Underflow: i_op1=0, i_op2=1 -> o_result=47'h7FFF_FFFF_FFFF (borrow=1, difference all ones).
- Cross-chunk borrow: i_op1=46'h1000, i_op2=1 -> o_result=47'h0FFF, which checks borrow propagation across the slice 0/1 boundary. Repeat with i_op1=46'h2000_0000_0000, i_op2=1 -> 47'h1FFF_FFFF_FFFF, which checks the partial last slice.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1, o_result constant, o_ready=0, and a new i_valid pulse is ignored. Release i_ready -> IDLE, o_ready=1 next cycle.
- Reset mid-op: drop i_rst_n for one edge at BUSY cnt=2 -> next cycle IDLE, o_valid=0, o_result=0, and no later o_valid for the aborted operation. A fresh 7-2 operation then returns 47'h5.
- With SUB_SIGNED_OVF_EN: i_op1=46'h2000_0000_0000 (-2^45), i_op2=1 -> o_ovf=1. Case 5-3 -> o_ovf=0.

Source files
------------

// File: rtl/cla_sub_46bit_seq.sv
// rtl/cla_sub_46bit_seq.sv - multi-cycle sliced carry-lookahead subtractor, result {borrow, difference}
// Optional signed-overflow output o_ovf is built when SUB_SIGNED_OVF_EN is defined.
module cla_sub_46bit_seq #(
  parameter int WIDTH = 46,
  parameter int CHUNK = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int NCHUNK    = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LAST_BITS = WIDTH - CHUNK * (NCHUNK - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2n_q, op2n_d, diff_q, diff_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] a, b, g, p, s;
  logic [CHUNK:0]   carry;
  logic             cout, last;

  // Current slice: operand bits above WIDTH read as zero in the partial last slice.
  always_comb begin
    logic pp, cc;
    a = '0;
    b = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (CNT_W'(k / CHUNK) == cnt_q) begin
        a[k % CHUNK] = op1_q[k];
        b[k % CHUNK] = op2n_q[k];
      end
    end
    g = a & b;
    p = a | b;
    carry[0] = c_q;
    for (int i = 0; i < CHUNK; i++) begin
      pp = 1'b1;
      cc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      carry[i+1] = cc | (pp & c_q);
    end
    s    = a ^ b ^ carry[CHUNK-1:0];
    last = (cnt_q == LAST_CNT);
    cout = last ? carry[LAST_BITS] : carry[CHUNK];
  end

  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2n_d   = op2n_q;
    diff_d   = diff_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op1_d   = i_op1;
          op2n_d  = ~i_op2;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < WIDTH; k++) begin
          if (CNT_W'(k / CHUNK) == cnt_q) diff_d[k] = s[k % CHUNK];
        end
        c_d   = cout;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d    = '0;
          state_d  = DONE;
          result_d = {~cout, diff_d};
`ifdef SUB_SIGNED_OVF_EN
          ovf_d    = (op1_q[WIDTH-1] ^ ~op2n_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ op1_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2n_q   <= '0;
      diff_q   <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2n_q   <= op2n_d;
      diff_q   <= diff_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_ready  = (state_q == IDLE) & i_rst_n;
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;
`ifdef SUB_SIGNED_OVF_EN
  assign o_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_46bit_seq.sv
// tb/tb_cla_sub_46bit_seq.sv - randomized self-checking bench for cla_sub_46bit_seq
module tb_cla_sub_46bit_seq;
  localparam int W = 46;

  logic           clk = 1'b0;
  logic           rst_n, i_valid, i_ready, o_ready, o_valid;
  logic [W-1:0]   op1, op2;
  logic [W:0]     o_result;
`ifdef SUB_SIGNED_OVF_EN
  logic           o_ovf;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_sub_46bit_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op1(op1), .i_op2(op2), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result)
`ifdef SUB_SIGNED_OVF_EN
    , .o_ovf(o_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Borrow falls out of a one-bit-wider unsigned subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input int stall);
    int k;
    k = 0;
    while (o_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq($sformatf("%s idle_ready", tag), 64'(o_ready), 64'd1);
    op1 = a;
    op2 = b;
    i_valid = 1'b1;
    i_ready = (stall == 0);
    @(negedge clk);
    i_valid = 1'b0;
    op1 = rand_op();
    op2 = rand_op();
    check_eq($sformatf("%s busy_ready", tag), 64'(o_ready), 64'd0);
    k = 1;
    while (o_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq($sformatf("%s latency", tag), 64'(k - 1), 64'd4);
    check_eq($sformatf("%s result", tag), 64'(o_result), 64'(exp));
`ifdef SUB_SIGNED_OVF_EN
    check_eq($sformatf("%s ovf", tag), 64'(o_ovf), 64'(ref_ovf(a, b)));
`endif
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq($sformatf("%s hold_valid", tag), 64'(o_valid), 64'd1);
      check_eq($sformatf("%s hold_result", tag), 64'(o_result), 64'(exp));
      check_eq($sformatf("%s hold_ready", tag), 64'(o_ready), 64'd0);
      if (s == 1) begin
        i_valid = 1'b1;
        op1 = rand_op();
        op2 = rand_op();
      end else begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check_eq($sformatf("%s post_valid", tag), 64'(o_valid), 64'd0);
    check_eq($sformatf("%s post_ready", tag), 64'(o_ready), 64'd1);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit seen;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst valid", 64'(o_valid), 64'd0);
    check_eq("rst result", 64'(o_result), 64'd0);
    check_eq("rst ready", 64'(o_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release ready", 64'(o_ready), 64'd1);

    run_op("basic", 46'd5, 46'd3, 47'h0_0000_0000_0002, 0);
    run_op("underflow", 46'd0, 46'd1, 47'h7FFF_FFFF_FFFF, 0);
    run_op("xchunk", 46'h1000, 46'd1, 47'h0FFF, 0);
    run_op("lastslice", 46'h2000_0000_0000, 46'd1, 47'h1FFF_FFFF_FFFF, 0);
    run_op("backpressure", 46'h1234_5678_9ABC, 46'h0FED_CBA9_8765,
           ref_sub(46'h1234_5678_9ABC, 46'h0FED_CBA9_8765), 5);

    // Abort an operation mid-flight with a one-edge reset at cnt=2.
    while (o_ready !== 1'b1) @(negedge clk);
    op1 = 46'd9;
    op2 = 46'd4;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort valid", 64'(o_valid), 64'd0);
    check_eq("abort result", 64'(o_result), 64'd0);
    check_eq("abort ready", 64'(o_ready), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check_eq("abort no_result", 64'(seen), 64'd0);
    run_op("after_abort", 46'd7, 46'd2, 47'h5, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: begin a = rand_op(); b = a; end
        1: begin a = rand_op(); b = '0; end
        2: begin a = rand_op(); b = '1; end
        3: begin a = 46'd1 << $urandom_range(0, W - 1); b = 46'd1 << $urandom_range(0, W - 1); end
        default: begin a = rand_op(); b = rand_op(); end
      endcase
      run_op($sformatf("rand%0d", n), a, b, ref_sub(a, b), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
